// File: rtl/tnn_feature_framer.sv
// Frames 2-bit feature beats onto the classifier inputs, samples cls_in after SETTLE cycles, returns one result per frame.
// Latency: m_valid SETTLE+1 cycles after the last beat (next cycle for bad-length frames); s_ready low while a result is outstanding.
module tnn_feature_framer #(
  parameter int NFEAT  = 6,
  parameter int SETTLE = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [1:0]       s_data,
  input  logic             s_last,
  output logic [1:0]       input_a,
  output logic [1:0]       input_b,
  output logic [1:0]       input_c,
  output logic [1:0]       input_d,
  output logic [1:0]       input_e,
  output logic [1:0]       input_f,
  input  logic             cls_in,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_class,
  output logic             m_err,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] pos_cnt
);
  localparam int               IDX_W    = $clog2(NFEAT);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NFEAT - 1);
  localparam logic [3:0]       SET_LAST = 4'(SETTLE - 1);

  typedef enum logic [1:0] {ST_COLLECT, ST_DRAIN, ST_SETTLE, ST_OUT} state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NFEAT-1:0][1:0]  feat_q, feat_d;
  logic [3:0]             set_q, set_d;
  logic                   rdy_q, rdy_d;
  logic                   cls_q, cls_d;
  logic                   err_q, err_d;
  logic [CNT_W-1:0]       fcnt_q, fcnt_d;
  logic [CNT_W-1:0]       pcnt_q, pcnt_d;
  logic                   accept;

  assign accept = s_valid & rdy_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    feat_d  = feat_q;
    set_d   = set_q;
    cls_d   = cls_q;
    err_d   = err_q;
    fcnt_d  = fcnt_q;
    pcnt_d  = pcnt_q;
    case (state_q)
      ST_COLLECT: begin
        if (accept) begin
          if (s_last && idx_q != IDX_LAST) begin
            feat_d  = '0;
            err_d   = 1'b1;
            cls_d   = 1'b0;
            state_d = ST_OUT;
          end else begin
            feat_d[idx_q] = s_data;
            if (idx_q == IDX_LAST) begin
              set_d   = '0;
              state_d = s_last ? ST_SETTLE : ST_DRAIN;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
      end
      ST_DRAIN: begin
        if (accept && s_last) begin
          feat_d  = '0;
          err_d   = 1'b1;
          cls_d   = 1'b0;
          state_d = ST_OUT;
        end
      end
      ST_SETTLE: begin
        // Features are frozen here, so cls_in is stable by the last settle cycle.
        if (set_q == SET_LAST) begin
          cls_d   = cls_in;
          state_d = ST_OUT;
        end else begin
          set_d = set_q + 1'b1;
        end
      end
      ST_OUT: begin
        if (m_ready) begin
          if (fcnt_q != '1) fcnt_d = fcnt_q + 1'b1;
          if (cls_q && !err_q && pcnt_q != '1) pcnt_d = pcnt_q + 1'b1;
          idx_d   = '0;
          err_d   = 1'b0;
          cls_d   = 1'b0;
          state_d = ST_COLLECT;
        end
      end
      default: state_d = ST_COLLECT;
    endcase
    rdy_d = (state_d == ST_COLLECT) || (state_d == ST_DRAIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_COLLECT;
      idx_q   <= '0;
      feat_q  <= '0;
      set_q   <= '0;
      rdy_q   <= 1'b0;
      cls_q   <= 1'b0;
      err_q   <= 1'b0;
      fcnt_q  <= '0;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      feat_q  <= feat_d;
      set_q   <= set_d;
      rdy_q   <= rdy_d;
      cls_q   <= cls_d;
      err_q   <= err_d;
      fcnt_q  <= fcnt_d;
      pcnt_q  <= pcnt_d;
    end
  end

  assign s_ready   = rdy_q;
  assign m_valid   = (state_q == ST_OUT);
  assign m_class   = cls_q;
  assign m_err     = err_q;
  assign frame_cnt = fcnt_q;
  assign pos_cnt   = pcnt_q;
  assign input_a   = feat_q[0];
  assign input_b   = feat_q[1];
  assign input_c   = feat_q[2];
  assign input_d   = feat_q[3];
  assign input_e   = feat_q[4];
  assign input_f   = feat_q[5];

endmodule
